// File: rtl/fifo_sc_drain.sv
// -----------------------------------------------------------------------------
// fifo_sc_drain
//   Downstream stage of the single-clock FIFO. Drains the FIFO's 1-cycle-latency
//   read port into a 3-entry skid buffer and presents the head word as a
//   valid/ready stream. Full throughput is kept without any combinational path
//   from m_ready to fifo_read. The stream is framed into fixed-length packets
//   with m_sop/m_eop.
//
//   Optional build macro: FIFO_SC_DRAIN_STATS_EN adds the stat_beats and
//   stat_stalls counters and their output ports.
//
// Ports
//   clk         in   1       clock, all logic on posedge
//   rst         in   1       asynchronous, active-high reset
//   fifo_empty  in   1       FIFO empty flag
//   fifo_read   out  1       FIFO read strobe
//   fifo_data   in   W       FIFO data_out, valid the cycle after a read
//   fifo_valid  in   1       FIFO valid_out, high the cycle after a read
//   m_data      out  W       stream data (head of the skid buffer)
//   m_valid     out  1       stream valid
//   m_ready     in   1       stream ready
//   m_sop       out  1       first beat of a packet (qualified by m_valid)
//   m_eop       out  1       last beat of a packet (qualified by m_valid)
//   err         out  1       sticky protocol / overflow error
//   stat_beats  out  32      handshake count   (FIFO_SC_DRAIN_STATS_EN only)
//   stat_stalls out  32      stalled-cycle count (FIFO_SC_DRAIN_STATS_EN only)
// -----------------------------------------------------------------------------
module fifo_sc_drain #(
  parameter int W       = 16,
  parameter int PKT_LEN = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fifo_empty,
  output logic         fifo_read,
  input  logic [W-1:0] fifo_data,
  input  logic         fifo_valid,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_sop,
  output logic         m_eop,
  output logic         err
`ifdef FIFO_SC_DRAIN_STATS_EN
  ,
  output logic [31:0]  stat_beats,
  output logic [31:0]  stat_stalls
`endif
);

  localparam int            BW        = $clog2(PKT_LEN) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  // Advance a skid pointer, wrapping 2 -> 0.
  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    logic [1:0] n;
    if (p == 2'd2) begin
      n = 2'd0;
    end else begin
      n = p + 2'd1;
    end
    return n;
  endfunction

  logic [W-1:0]  r_mem [3];
  logic [1:0]    r_wptr;
  logic [1:0]    r_rptr;
  logic [1:0]    r_occ;
  logic          r_pend;
  logic [BW-1:0] r_beat;
  logic          r_err;

  logic          w_pop;
  logic          w_cap;
  logic          w_overflow;
  logic [2:0]    w_inflight;
  logic [1:0]    w_occ_next;
  logic [BW-1:0] w_beat_next;
  logic [W-1:0]  w_head;

  // Words already in the skid plus the one on its way must never exceed 3,
  // so a read is only issued when a slot is guaranteed for its data.
  // rst also gates the strobe so the read port is idle while reset is held.
  assign w_inflight = {1'b0, r_occ} + {2'b00, r_pend};
  assign fifo_read  = !rst && !fifo_empty && (w_inflight < 3'd3);

  assign w_pop      = m_valid && m_ready;
  // A capture into a full buffer is only legal when the head leaves the
  // same cycle; otherwise the word is dropped and flagged.
  assign w_overflow = fifo_valid && (r_occ == 2'd3) && !w_pop;
  assign w_cap      = fifo_valid && !w_overflow;

  assign m_valid = (r_occ != 2'd0);
  assign m_data  = w_head;
  assign m_sop   = (r_beat == {BW{1'b0}});
  assign m_eop   = (r_beat == LAST_BEAT);
  assign err     = r_err;

  // Head-word mux; the read pointer never takes the value 3.
  always_comb begin
    w_head = {W{1'b0}};
    case (r_rptr)
      2'd0:    w_head = r_mem[0];
      2'd1:    w_head = r_mem[1];
      2'd2:    w_head = r_mem[2];
      default: w_head = {W{1'b0}};
    endcase
  end

  // Occupancy update: capture and pop in the same cycle cancel out.
  always_comb begin
    w_occ_next = r_occ;
    case ({w_cap, w_pop})
      2'b10:   w_occ_next = r_occ + 2'd1;
      2'b01:   w_occ_next = r_occ - 2'd1;
      default: w_occ_next = r_occ;
    endcase
  end

  // Beat counter for packet framing, wrapping after the eop beat.
  always_comb begin
    w_beat_next = r_beat;
    if (w_pop) begin
      if (r_beat == LAST_BEAT) begin
        w_beat_next = {BW{1'b0}};
      end else begin
        w_beat_next = r_beat + {{(BW-1){1'b0}}, 1'b1};
      end
    end else begin
      w_beat_next = r_beat;
    end
  end

  // Skid buffer storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_mem[i] <= {W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_cap && (r_wptr == 2'(i))) begin
          r_mem[i] <= fifo_data;
        end
      end
    end
  end

  // Pointers, occupancy, pending-read flag and beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= 2'd0;
      r_rptr <= 2'd0;
      r_occ  <= 2'd0;
      r_pend <= 1'b0;
      r_beat <= {BW{1'b0}};
    end else begin
      if (w_cap) begin
        r_wptr <= next_ptr(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= next_ptr(r_rptr);
      end
      r_occ  <= w_occ_next;
      r_pend <= fifo_read;
      r_beat <= w_beat_next;
    end
  end

  // Sticky error: unsolicited FIFO data or a capture into a full buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((fifo_valid && !r_pend) || w_overflow) begin
      r_err <= 1'b1;
    end
  end

`ifdef FIFO_SC_DRAIN_STATS_EN
  logic [31:0] r_stat_beats;
  logic [31:0] r_stat_stalls;

  // Free-running, wrapping handshake and stall counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_beats  <= 32'd0;
      r_stat_stalls <= 32'd0;
    end else begin
      if (w_pop) begin
        r_stat_beats <= r_stat_beats + 32'd1;
      end
      if (m_valid && !m_ready) begin
        r_stat_stalls <= r_stat_stalls + 32'd1;
      end
    end
  end

  assign stat_beats  = r_stat_beats;
  assign stat_stalls = r_stat_stalls;
`endif

endmodule
